// File: rtl/sentinel_access_fsm.sv
// -----------------------------------------------------------------------------
// sentinel_access_fsm
//
// Access-control sequencer that sits directly behind the Sentinel key
// comparator. Each rising edge of the key-submission strobe samples the
// comparator's match bit:
//   - a match opens a timed unlock window;
//   - MAX_FAILS consecutive mismatches start a timed lockout and raise the
//     intrusion alarm.
// Every output is registered because it drives the Sentinel status pins.
//
// Parameters
//   MAX_FAILS       consecutive mismatches that trigger lockout (1..7)
//   UNLOCK_CYCLES   unlock window length in enabled clock cycles (>= 1)
//   LOCKOUT_CYCLES  lockout length in enabled clock cycles (>= 1)
//
// Ports
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   ena         in   global enable; while low all state, counters and timers hold
//   attempt     in   key-submission level; only its rising edge counts
//   key_match   in   comparator result, sampled on an attempt edge
//   unlocked    out  high throughout the unlock window
//   lockout     out  high throughout the lockout period
//   alarm       out  intrusion flag
//   fail_count  out  consecutive mismatches so far (3 bits)
//   state       out  LOCKED=00, GRANTED=01, LOCKOUT=10 (11 unused)
//
// Build option
//   CITADEL_STICKY_ALARM_EN
//     defined   : alarm, once raised, stays high until rst_n is asserted.
//     undefined : alarm is high only while in LOCKOUT and drops in the same
//                 cycle the FSM returns to LOCKED.
// -----------------------------------------------------------------------------
module sentinel_access_fsm #(
    parameter int MAX_FAILS      = 3,
    parameter int UNLOCK_CYCLES  = 256,
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       attempt,
    input  logic       key_match,
    output logic       unlocked,
    output logic       lockout,
    output logic       alarm,
    output logic [2:0] fail_count,
    output logic [1:0] state
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int MAX_WIN  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                               : LOCKOUT_CYCLES;
    localparam int TIMER_W  = ($clog2(MAX_WIN) < 1) ? 1 : $clog2(MAX_WIN);

    // The timer is loaded with N-1 and the exit happens in the cycle it reads
    // 0, so a window spans exactly N enabled cycles.
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

    // Compared against a 4-bit incremented count so MAX_FAILS=7 never aliases.
    localparam logic [3:0] FAIL_LIMIT = 4'(MAX_FAILS);

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'b00,
        ST_GRANTED = 2'b01,
        ST_LOCKOUT = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t               state_reg;
    logic [TIMER_W-1:0]   timer_reg;
    logic [2:0]           fail_reg;
    logic                 attempt_q_reg;
    logic                 unlocked_reg;
    logic                 lockout_reg;
    logic                 alarm_reg;

    // -------------------------------------------------------------------------
    // Next-state signals
    // -------------------------------------------------------------------------
    state_t               state_next;
    logic [TIMER_W-1:0]   timer_next;
    logic [2:0]           fail_next;
    logic                 alarm_next;
    logic [3:0]           fail_inc;
    logic                 attempt_edge;

    // A held-high attempt counts once: attempt_q only follows attempt while
    // enabled, so a strobe that rises and falls while ena is low is never seen.
    // attempt_q resets to 0, so an attempt already high at reset release is
    // taken as an edge on the first enabled cycle.
    assign attempt_edge = attempt & ~attempt_q_reg & ena;

    assign fail_inc     = {1'b0, fail_reg} + 4'd1;

    // -------------------------------------------------------------------------
    // Next-state / datapath decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        fail_next  = fail_reg;

        case (state_reg)
            ST_LOCKED: begin
                if (attempt_edge) begin
                    if (key_match) begin
                        state_next = ST_GRANTED;
                        timer_next = UNLOCK_LOAD;
                        fail_next  = 3'd0;
                    end else if (fail_inc == FAIL_LIMIT) begin
                        state_next = ST_LOCKOUT;
                        timer_next = LOCKOUT_LOAD;
                        fail_next  = FAIL_LIMIT[2:0];
                    end else begin
                        fail_next  = fail_inc[2:0];
                    end
                end
            end

            // Attempt edges are deliberately ignored in both timed states.
            // The timer stops at 0 instead of wrapping; it is only reloaded
            // when a timed state is entered.
            ST_GRANTED: begin
                if (timer_reg == '0) begin
                    state_next = ST_LOCKED;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end

            ST_LOCKOUT: begin
                if (timer_reg == '0) begin
                    state_next = ST_LOCKED;
                    fail_next  = 3'd0;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end

            // Unused encoding: fall back to the safe state with a clean slate.
            default: begin
                state_next = ST_LOCKED;
                timer_next = '0;
                fail_next  = 3'd0;
            end
        endcase
    end

    // Alarm follows the state being entered; the sticky build keeps it latched
    // once raised so an operator sees past intrusions until a reset.
`ifdef CITADEL_STICKY_ALARM_EN
    assign alarm_next = alarm_reg | (state_next == ST_LOCKOUT);
`else
    assign alarm_next = (state_next == ST_LOCKOUT);
`endif

    // -------------------------------------------------------------------------
    // Sequential state. Everything, including the edge detector, freezes while
    // ena is low, which stretches both timed windows by the stalled cycles.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_LOCKED;
            timer_reg     <= '0;
            fail_reg      <= 3'd0;
            attempt_q_reg <= 1'b0;
            unlocked_reg  <= 1'b0;
            lockout_reg   <= 1'b0;
            alarm_reg     <= 1'b0;
        end else if (ena) begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            fail_reg      <= fail_next;
            attempt_q_reg <= attempt;
            unlocked_reg  <= (state_next == ST_GRANTED);
            lockout_reg   <= (state_next == ST_LOCKOUT);
            alarm_reg     <= alarm_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from registers)
    // -------------------------------------------------------------------------
    assign unlocked   = unlocked_reg;
    assign lockout    = lockout_reg;
    assign alarm      = alarm_reg;
    assign fail_count = fail_reg;
    assign state      = state_reg;

endmodule
